// File: rtl/cabac_encode_bin_ctx.sv
`default_nettype none
// ============================================================================
// cabac_encode_bin_ctx : CABAC arithmetic bin encoder with a 40-entry context store
// Rev 1.0
// ============================================================================
module cabac_encode_bin_ctx (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_ctx_we,
  input  logic [5:0] i_ctx_widx,
  input  logic [6:0] i_ctx_wdata,
  input  logic       i_bin_valid,
  output logic       o_bin_ready,
  input  logic       i_bin,
  input  logic [5:0] i_ctx_idx,
  input  logic       i_bypass,
  input  logic       i_flush,
  output logic       o_bit_valid,
  output logic       o_bit,
  output logic       o_flush_done,
  output logic       o_err
);

  localparam int c_NUM_CTX = 40;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RENORM    = 3'd1;
  localparam logic [2:0] S_OUTST     = 3'd2;
  localparam logic [2:0] S_FLUSH_PUT = 3'd3;
  localparam logic [2:0] S_FLUSH_W1  = 3'd4;
  localparam logic [2:0] S_FLUSH_W2  = 3'd5;

  localparam int c_LPS_TAB [0:63][0:3] = '{
    '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
    '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
    '{ 95,116,137,158}, '{ 90,110,130,150}, '{ 85,104,123,142}, '{ 81, 99,117,135},
    '{ 77, 94,111,128}, '{ 73, 89,105,122}, '{ 69, 85,100,116}, '{ 66, 80, 95,110},
    '{ 62, 76, 90,104}, '{ 59, 72, 86, 99}, '{ 56, 69, 81, 94}, '{ 53, 65, 77, 89},
    '{ 51, 62, 73, 85}, '{ 48, 59, 69, 80}, '{ 46, 56, 66, 76}, '{ 43, 53, 63, 72},
    '{ 41, 50, 59, 69}, '{ 39, 48, 56, 65}, '{ 37, 45, 54, 62}, '{ 35, 43, 51, 59},
    '{ 33, 41, 48, 56}, '{ 32, 39, 46, 53}, '{ 30, 37, 43, 50}, '{ 29, 35, 41, 48},
    '{ 27, 33, 39, 45}, '{ 26, 31, 37, 43}, '{ 24, 30, 35, 41}, '{ 23, 28, 33, 39},
    '{ 22, 27, 32, 37}, '{ 21, 26, 30, 35}, '{ 20, 24, 29, 33}, '{ 19, 23, 27, 31},
    '{ 18, 22, 26, 30}, '{ 17, 21, 25, 28}, '{ 16, 20, 23, 27}, '{ 15, 19, 22, 25},
    '{ 14, 18, 21, 24}, '{ 14, 17, 20, 23}, '{ 13, 16, 19, 22}, '{ 12, 15, 18, 21},
    '{ 12, 14, 17, 20}, '{ 11, 14, 16, 19}, '{ 11, 13, 15, 18}, '{ 10, 12, 15, 17},
    '{ 10, 12, 14, 16}, '{  9, 11, 13, 15}, '{  9, 11, 12, 14}, '{  8, 10, 12, 14},
    '{  8,  9, 11, 13}, '{  7,  9, 11, 12}, '{  7,  9, 10, 12}, '{  7,  8, 10, 11},
    '{  6,  8,  9, 11}, '{  6,  7,  9, 10}, '{  6,  7,  8,  9}, '{  2,  2,  2,  2}
  };

  localparam int c_TRANS_LPS [0:63] = '{
     0,  0,  1,  2,  2,  4,  4,  5,  6,  7,  8,  9,  9, 11, 11, 12,
    13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
    24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
    33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
  };

  logic [2:0]  r_state, w_state_n, r_ret, w_ret_n, w_after;
  logic [9:0]  r_low, w_low_n;
  logic [8:0]  r_range, w_range_n;
  logic [15:0] r_outst, w_outst_n;
  logic        r_first, w_first_n, r_obit, w_obit_n, r_flushing, w_flushing_n;
  logic        r_err, w_err_n, r_bit_v, w_bit_v_n, r_bit, w_bit_n, r_fd, w_fd_n;
  logic [6:0]  r_ctx [0:c_NUM_CTX-1];

  logic [6:0]  w_ctx_rd;
  logic [5:0]  w_pst, w_pst_n;
  logic        w_mps, w_mps_n, w_is_lps;
  logic [1:0]  w_q;
  logic [7:0]  w_rlps;
  logic [8:0]  w_rmps, w_lsub;
  logic [10:0] w_byp;
  logic        w_accept, w_regular, w_upd_we, w_put, w_put_b, w_inc;

  assign w_ctx_rd  = (i_ctx_idx < 6'(c_NUM_CTX)) ? r_ctx[i_ctx_idx] : 7'd0;
  assign w_pst     = w_ctx_rd[6:1];
  assign w_mps     = w_ctx_rd[0];
  assign w_q       = r_range[7:6];
  assign w_rlps    = 8'(c_LPS_TAB[w_pst][w_q]);
  assign w_rmps    = r_range - {1'b0, w_rlps};
  assign w_is_lps  = (i_bin != w_mps);
  assign w_pst_n   = w_is_lps ? 6'(c_TRANS_LPS[w_pst]) :
                     ((w_pst >= 6'd62) ? 6'd62 : w_pst + 6'd1);
  assign w_mps_n   = (w_is_lps && (w_pst == 6'd0)) ? ~w_mps : w_mps;
  assign w_accept  = (r_state == S_IDLE) && i_bin_valid && !i_start && !rst;
  assign w_regular = w_accept && !i_flush && !i_bypass;
  assign w_upd_we  = w_regular && (i_ctx_idx < 6'(c_NUM_CTX));
  assign w_byp     = {r_low, 1'b0} + (i_bin ? {2'b00, r_range} : 11'd0);
  // Low after the RenormE subtraction; only the 9 bits that survive the shift matter.
  assign w_lsub    = r_low[9] ? r_low[8:0] : (r_low[8] ? {1'b0, r_low[7:0]} : r_low[8:0]);

  always_ff @(posedge clk) begin
    if (rst || i_start) r_state <= S_IDLE;
    else                r_state <= w_state_n;
  end

  always_comb begin
    w_low_n = r_low;      w_range_n = r_range;  w_outst_n = r_outst;
    w_first_n = r_first;  w_ret_n = r_ret;      w_obit_n = r_obit;
    w_flushing_n = r_flushing;  w_err_n = r_err;
    w_bit_v_n = 1'b0;  w_bit_n = 1'b0;  w_fd_n = 1'b0;
    w_put = 1'b0;  w_put_b = 1'b0;  w_inc = 1'b0;  w_after = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_flush) begin
            w_low_n      = r_low + {1'b0, (r_range - 9'd2)};
            w_range_n    = 9'd2;
            w_flushing_n = 1'b1;
            w_after      = S_RENORM;
          end else if (i_bypass) begin
            w_after = S_IDLE;
            if (w_byp[10]) begin
              w_put = 1'b1;  w_put_b = 1'b1;  w_low_n = w_byp[9:0];
            end else if (!w_byp[9]) begin
              w_put = 1'b1;  w_low_n = w_byp[9:0];
            end else begin
              w_inc = 1'b1;  w_low_n = {1'b0, w_byp[8:0]};
            end
          end else begin
            if (w_is_lps) begin
              w_low_n   = r_low + {1'b0, w_rmps};
              w_range_n = {1'b0, w_rlps};
            end else begin
              w_range_n = w_rmps;
            end
            w_after = w_range_n[8] ? S_IDLE : S_RENORM;
          end
        end
      end
      S_RENORM: begin
        if (r_low[9]) begin
          w_put = 1'b1;  w_put_b = 1'b1;
        end else if (!r_low[8]) begin
          w_put = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
        w_low_n   = {w_lsub, 1'b0};
        w_range_n = {r_range[7:0], 1'b0};
        w_after   = !w_range_n[8] ? S_RENORM : (r_flushing ? S_FLUSH_PUT : S_IDLE);
      end
      S_OUTST: begin
        w_bit_v_n = 1'b1;
        w_bit_n   = r_obit;
        w_outst_n = r_outst - 16'd1;
        w_after   = (r_outst == 16'd1) ? r_ret : S_OUTST;
      end
      S_FLUSH_PUT: begin
        w_put = 1'b1;  w_put_b = r_low[9];  w_after = S_FLUSH_W1;
      end
      S_FLUSH_W1: begin
        w_bit_v_n = 1'b1;  w_bit_n = r_low[8];  w_after = S_FLUSH_W2;
      end
      S_FLUSH_W2: begin
        w_bit_v_n = 1'b1;  w_bit_n = 1'b1;  w_fd_n = 1'b1;
        w_flushing_n = 1'b0;  w_after = S_IDLE;
      end
      default: w_after = S_IDLE;
    endcase

    if (w_inc) begin
      if (r_outst == 16'hFFFF) w_err_n = 1'b1;
      else                     w_outst_n = r_outst + 16'd1;
    end

    // PutBit: the first bit of a slice is swallowed; pending outstanding bits detour via OUTST.
    w_state_n = w_after;
    if (w_put) begin
      if (r_first) begin
        w_first_n = 1'b0;
      end else begin
        w_bit_v_n = 1'b1;
        w_bit_n   = w_put_b;
      end
      if (r_outst != 16'd0) begin
        w_ret_n   = w_after;
        w_obit_n  = ~w_put_b;
        w_state_n = S_OUTST;
      end
    end
  end

  always_comb begin
    o_bin_ready  = (r_state == S_IDLE);
    o_bit_valid  = r_bit_v;
    o_bit        = r_bit;
    o_flush_done = r_fd;
    o_err        = r_err;
  end

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_low      <= 10'd0;
      r_range    <= 9'd510;
      r_outst    <= 16'd0;
      r_first    <= 1'b1;
      r_ret      <= S_IDLE;
      r_obit     <= 1'b0;
      r_flushing <= 1'b0;
      r_bit_v    <= 1'b0;
      r_bit      <= 1'b0;
      r_fd       <= 1'b0;
      r_err      <= rst ? 1'b0 : r_err;
    end else begin
      r_low      <= w_low_n;
      r_range    <= w_range_n;
      r_outst    <= w_outst_n;
      r_first    <= w_first_n;
      r_ret      <= w_ret_n;
      r_obit     <= w_obit_n;
      r_flushing <= w_flushing_n;
      r_bit_v    <= w_bit_v_n;
      r_bit      <= w_bit_n;
      r_fd       <= w_fd_n;
      r_err      <= w_err_n;
    end
  end

  // Later write wins: a bin update overrides an init write to the same entry.
  always_ff @(posedge clk) begin
    if (i_ctx_we && (i_ctx_widx < 6'(c_NUM_CTX))) r_ctx[i_ctx_widx] <= i_ctx_wdata;
    if (w_upd_we) r_ctx[i_ctx_idx] <= {w_pst_n, w_mps_n};
  end

endmodule
`default_nettype wire

// File: tb/tb_cabac_encode_bin_ctx.sv
`default_nettype none
// ============================================================================
// tb_cabac_encode_bin_ctx : randomized bench against a software CABAC encoder model
// Rev 1.0
// ============================================================================
module tb_cabac_encode_bin_ctx;

  logic       clk = 1'b0;
  logic       rst, i_start, i_ctx_we, i_bin_valid, i_bin, i_bypass, i_flush;
  logic [5:0] i_ctx_widx, i_ctx_idx;
  logic [6:0] i_ctx_wdata;
  logic       o_bin_ready, o_bit_valid, o_bit, o_flush_done, o_err;

  cabac_encode_bin_ctx dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_ctx_we(i_ctx_we), .i_ctx_widx(i_ctx_widx), .i_ctx_wdata(i_ctx_wdata),
    .i_bin_valid(i_bin_valid), .o_bin_ready(o_bin_ready), .i_bin(i_bin),
    .i_ctx_idx(i_ctx_idx), .i_bypass(i_bypass), .i_flush(i_flush),
    .o_bit_valid(o_bit_valid), .o_bit(o_bit), .o_flush_done(o_flush_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int lps_tab [64][4] = '{
    '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
    '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
    '{ 95,116,137,158}, '{ 90,110,130,150}, '{ 85,104,123,142}, '{ 81, 99,117,135},
    '{ 77, 94,111,128}, '{ 73, 89,105,122}, '{ 69, 85,100,116}, '{ 66, 80, 95,110},
    '{ 62, 76, 90,104}, '{ 59, 72, 86, 99}, '{ 56, 69, 81, 94}, '{ 53, 65, 77, 89},
    '{ 51, 62, 73, 85}, '{ 48, 59, 69, 80}, '{ 46, 56, 66, 76}, '{ 43, 53, 63, 72},
    '{ 41, 50, 59, 69}, '{ 39, 48, 56, 65}, '{ 37, 45, 54, 62}, '{ 35, 43, 51, 59},
    '{ 33, 41, 48, 56}, '{ 32, 39, 46, 53}, '{ 30, 37, 43, 50}, '{ 29, 35, 41, 48},
    '{ 27, 33, 39, 45}, '{ 26, 31, 37, 43}, '{ 24, 30, 35, 41}, '{ 23, 28, 33, 39},
    '{ 22, 27, 32, 37}, '{ 21, 26, 30, 35}, '{ 20, 24, 29, 33}, '{ 19, 23, 27, 31},
    '{ 18, 22, 26, 30}, '{ 17, 21, 25, 28}, '{ 16, 20, 23, 27}, '{ 15, 19, 22, 25},
    '{ 14, 18, 21, 24}, '{ 14, 17, 20, 23}, '{ 13, 16, 19, 22}, '{ 12, 15, 18, 21},
    '{ 12, 14, 17, 20}, '{ 11, 14, 16, 19}, '{ 11, 13, 15, 18}, '{ 10, 12, 15, 17},
    '{ 10, 12, 14, 16}, '{  9, 11, 13, 15}, '{  9, 11, 12, 14}, '{  8, 10, 12, 14},
    '{  8,  9, 11, 13}, '{  7,  9, 11, 12}, '{  7,  9, 10, 12}, '{  7,  8, 10, 11},
    '{  6,  8,  9, 11}, '{  6,  7,  9, 10}, '{  6,  7,  8,  9}, '{  2,  2,  2,  2}
  };
  int trans_lps [64] = '{
     0,  0,  1,  2,  2,  4,  4,  5,  6,  7,  8,  9,  9, 11, 11, 12,
    13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
    24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
    33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
  };

  // Reference encoder state
  int         m_low, m_range, m_outst;
  bit         m_first;
  int         m_pst [40];
  bit         m_mps [40];
  logic [1:0] exp_q [$];   // {flush_done, bit} in emission order
  bit         log_q [$];
  int         n_tests = 0, n_fail = 0, bits_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_push(input bit b, input bit fd);
    exp_q.push_back({fd, b});
    log_q.push_back(b);
  endfunction

  function automatic void m_put(input bit b);
    if (m_first) m_first = 1'b0;
    else         m_push(b, 1'b0);
    while (m_outst > 0) begin
      m_push(!b, 1'b0);
      m_outst--;
    end
  endfunction

  function automatic void m_renorm();
    while (m_range < 256) begin
      if (m_low < 256) m_put(1'b0);
      else if (m_low >= 512) begin m_low -= 512; m_put(1'b1); end
      else begin m_low -= 256; m_outst++; end
      m_range = m_range * 2;
      m_low   = m_low * 2;
    end
  endfunction

  function automatic void m_start();
    m_low = 0; m_range = 510; m_outst = 0; m_first = 1'b1;
  endfunction

  function automatic void m_regular(input int idx, input bit b);
    int pst  = m_pst[idx];
    bit mps  = m_mps[idx];
    int rlps = lps_tab[pst][(m_range / 64) % 4];
    m_range -= rlps;
    if (b != mps) begin
      m_low  += m_range;
      m_range = rlps;
      if (pst == 0) m_mps[idx] = !mps;
      m_pst[idx] = trans_lps[pst];
    end else begin
      m_pst[idx] = (pst + 1 > 62) ? 62 : pst + 1;
    end
    m_renorm();
  endfunction

  function automatic void m_bypass(input bit b);
    m_low = m_low * 2 + (b ? m_range : 0);
    if (m_low >= 1024) begin m_put(1'b1); m_low -= 1024; end
    else if (m_low < 512) m_put(1'b0);
    else begin m_low -= 512; m_outst++; end
  endfunction

  function automatic void m_flush();
    m_range -= 2;
    m_low   += m_range;
    m_range  = 2;
    m_renorm();
    m_put(1'((m_low / 512) % 2));
    m_push(1'((m_low / 256) % 2), 1'b0);
    m_push(1'b1, 1'b1);
  endfunction

  function automatic logic [6:0] m_ctx(input int idx);
    return {6'(m_pst[idx]), m_mps[idx]};
  endfunction

  task automatic do_bin(input bit b, input int idx, input bit byp, input bit fl,
                        input bit we = 1'b0, input int widx = 0, input int wd = 0);
    int n = 0;
    @(negedge clk);
    while (!o_bin_ready && n < 500) begin @(negedge clk); n++; end
    if (!o_bin_ready) begin
      check("bin_ready_wait", 32'(o_bin_ready), 32'd1);
      return;
    end
    i_bin_valid = 1'b1; i_bin = b; i_ctx_idx = 6'(idx); i_bypass = byp; i_flush = fl;
    i_ctx_we = we; i_ctx_widx = 6'(widx); i_ctx_wdata = 7'(wd);
    if (fl)       m_flush();
    else if (byp) m_bypass(b);
    else          m_regular(idx, b);
    if (we && (fl || byp || widx != idx)) begin
      m_pst[widx] = (wd / 2) % 64;
      m_mps[widx] = 1'(wd % 2);
    end
    @(posedge clk); #1;
    i_bin_valid = 1'b0; i_ctx_we = 1'b0;
  endtask

  task automatic ctx_write(input int idx, input int wd);
    @(negedge clk);
    i_ctx_we = 1'b1; i_ctx_widx = 6'(idx); i_ctx_wdata = 7'(wd);
    m_pst[idx] = (wd / 2) % 64; m_mps[idx] = 1'(wd % 2);
    @(posedge clk); #1;
    i_ctx_we = 1'b0;
  endtask

  task automatic start_slice();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    m_start();
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !o_bin_ready) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Output stream compare against the model's expected bit queue
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (o_bit_valid) begin
        bits_seen++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_bit: got bit %0d, expected no bit", o_bit);
        end else begin
          e = exp_q.pop_front();
          check("bit_and_flush_done", {30'd0, o_flush_done, o_bit}, {30'd0, e});
        end
      end else if (o_flush_done) begin
        check("flush_done_without_bit", 32'(o_flush_done), 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0, kind, lval;
    rst = 1'b1; i_start = 1'b0; i_ctx_we = 1'b0; i_ctx_widx = '0; i_ctx_wdata = '0;
    i_bin_valid = 1'b0; i_bin = 1'b0; i_ctx_idx = '0; i_bypass = 1'b0; i_flush = 1'b0;
    for (int i = 0; i < 40; i++) begin m_pst[i] = 0; m_mps[i] = 1'b0; end
    m_start();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_bin_ready", 32'(o_bin_ready), 32'd1);
    check("reset_bit_valid", 32'(o_bit_valid), 32'd0);
    check("reset_bit", 32'(o_bit), 32'd0);
    check("reset_flush_done", 32'(o_flush_done), 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_range", 32'(dut.r_range), 32'd510);
    check("reset_low", 32'(dut.r_low), 32'd0);

    // MPS without renormalisation
    ctx_write(0, 0);
    do_bin(1'b0, 0, 1'b0, 1'b0);
    check("mps_range", 32'(dut.r_range), 32'd270);
    check("mps_ctx", 32'(dut.r_ctx[0]), 32'd2);
    check("mps_model_range", 32'(m_range), 32'd270);
    @(negedge clk);
    check("mps_ready_next", 32'(o_bin_ready), 32'd1);

    // LPS with one renorm iteration
    start_slice();
    ctx_write(0, 0);
    do_bin(1'b1, 0, 1'b0, 1'b0);
    check("lps_range", 32'(dut.r_range), 32'd240);
    check("lps_low", 32'(dut.r_low), 32'd270);
    check("lps_ctx", 32'(dut.r_ctx[0]), 32'd1);
    check("lps_ready_low", 32'(o_bin_ready), 32'd0);
    @(posedge clk); #1;
    check("lps_ready_back", 32'(o_bin_ready), 32'd1);
    check("lps_renorm_low", 32'(dut.r_low), 32'd28);
    check("lps_renorm_range", 32'(dut.r_range), 32'd480);
    check("lps_renorm_outst", 32'(dut.r_outst), 32'd1);
    check("lps_model", 32'(m_low * 65536 + m_range * 4 + m_outst), 32'(28 * 65536 + 480 * 4 + 1));

    // Bypass 1,1,0,0,1
    start_slice();
    log_q.delete();
    do_bin(1'b1, 0, 1'b1, 1'b0);
    do_bin(1'b1, 0, 1'b1, 1'b0);
    do_bin(1'b0, 0, 1'b1, 1'b0);
    do_bin(1'b0, 0, 1'b1, 1'b0);
    check("byp_outst", 32'(dut.r_outst), 32'd2);
    do_bin(1'b1, 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("byp_consecutive_valid", 32'(o_bit_valid), 32'd1);
    end
    check("byp_low", 32'(dut.r_low), 32'd462);
    check("byp_model_low", 32'(m_low), 32'd462);
    lval = 0;
    foreach (log_q[k]) lval = lval * 2 + int'(log_q[k]);
    check("byp_model_stream", 32'(lval * 16 + log_q.size()), 32'(4'b1100 * 16 + 4));
    drain();

    // Flush immediately after start
    start_slice();
    log_q.delete();
    seen0 = bits_seen;
    do_bin(1'b1, 0, 1'b0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check("flush_renorm_low", 32'(dut.r_low), 32'd0);
    check("flush_renorm_range", 32'(dut.r_range), 32'd256);
    check("flush_renorm_outst", 32'(dut.r_outst), 32'd7);
    drain();
    lval = 0;
    foreach (log_q[k]) lval = lval * 2 + int'(log_q[k]);
    check("flush_model_stream", 32'(lval), 32'(9'b111111101));
    check("flush_model_len", 32'(log_q.size()), 32'd9);
    check("flush_dut_len", 32'(bits_seen - seen0), 32'd9);

    // Reset during outstanding emission
    start_slice();
    do_bin(1'b1, 0, 1'b1, 1'b0);
    do_bin(1'b1, 0, 1'b1, 1'b0);
    do_bin(1'b0, 0, 1'b1, 1'b0);
    do_bin(1'b0, 0, 1'b1, 1'b0);
    do_bin(1'b1, 0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("rst_outst_bit_valid", 32'(o_bit_valid), 32'd0);
    check("rst_outst_ready", 32'(o_bin_ready), 32'd1);
    rst = 1'b0;
    m_start();
    check("rst_ctx_kept", 32'(dut.r_ctx[0]), 32'(m_ctx(0)));
    ctx_write(0, 0);
    do_bin(1'b0, 0, 1'b0, 1'b0);
    check("rst_mps_range", 32'(dut.r_range), 32'd270);
    check("rst_mps_ctx", 32'(dut.r_ctx[0]), 32'd2);

    // Randomized regular/bypass traffic with concurrent context writes
    start_slice();
    for (int i = 0; i < 40; i++) ctx_write(i, int'($urandom_range(0, 62)) * 2 + int'($urandom_range(0, 1)));
    for (int i = 0; i < 1500; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7)
        do_bin(1'($urandom_range(0, 1)), int'($urandom_range(0, 39)), 1'b0, 1'b0,
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, 39)),
               int'($urandom_range(0, 62)) * 2 + int'($urandom_range(0, 1)));
      else
        do_bin(1'($urandom_range(0, 1)), 0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 40; i++) check("rand_ctx", 32'(dut.r_ctx[i]), 32'(m_ctx(i)));
    do_bin(1'b1, 0, 1'b0, 1'b1);
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_err", 32'(o_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cabac_encode_bin_ctx.md
# cabac_encode_bin_ctx

Encoder-side counterpart of the context-coded bin decoder: holds 40 CABAC context models (pStateIdx, valMps), arithmetic-encodes regular, bypass and terminate/flush bins per H.265 9.3.4.3, and emits the resulting bitstream one bit per cycle to the downstream bit packer. It sits between the syntax-element binarizer and the slice-data bit writer in the encoder path.

## Interface
- No parameters; context count is fixed at 40 (indices 0..39).
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  slice start: reinitialises arithmetic state; contexts are untouched
- i_ctx_we  in  1  context init write strobe
- i_ctx_widx  in  6  context init index
- i_ctx_wdata  in  7  {pStateIdx[5:0], valMps}
- i_bin_valid  in  1  bin request
- o_bin_ready  out  1  encoder can accept a bin
- i_bin  in  1  bin value
- i_ctx_idx  in  6  context index for regular bins
- i_bypass  in  1  bypass bin, no context use
- i_flush  in  1  terminate bin = 1 followed by EncodeFlush
- o_bit_valid  out  1  output bit strobe; downstream always accepts
- o_bit  out  1  output bit
- o_flush_done  out  1  one-cycle pulse coincident with the last flush bit
- o_err  out  1  sticky: bitsOutstanding saturated

## Operation
- State: ivlLow 10 bits; ivlCurrRange 9 bits; bitsOutstanding 16 bits (saturates at 65535 and sets o_err); firstBitFlag; 40x7 context RAM (combinational read, write at the clock edge).
- rst or i_start: low=0, range=510, firstBitFlag=1, outstanding=0, FSM→IDLE. Both abort any operation in progress. Context RAM is not reset.
- i_ctx_we writes the RAM in any state. If it coincides with an accepted regular bin on the same index, the bin's update wins.
- FSM states:
  - IDLE: o_bin_ready=1. A bin is accepted when i_bin_valid=1.
  - RENORM: one RenormE iteration per cycle.
  - OUTST: emits one outstanding bit per cycle.
  - FLUSH_PUT: PutBit((low>>9)&1).
  - FLUSH_W1: emits (low>>8)&1.
  - FLUSH_W2: emits 1.
- Regular bin, applied at the accept edge:
  - q=(range>>6)&3; rLps=rangeTabLps[pst][q] (Table 9-46); range-=rLps.
  - MPS: pst=transIdxMps (min(pst+1,62)).
  - LPS: low+=range; range=rLps; if pst==0, mps flips; pst=transIdxLps[pst] (Table 9-47).
  - Context write-back happens at the same edge.
  - Go to RENORM if the new range<256, else stay in IDLE.
- Bypass bin: low=(low<<1)+(i_bin?range:0) in 11 bits.
  - ≥1024: PutBit(1), low-=1024.
  - <512: PutBit(0).
  - Otherwise: low-=512, outstanding++.
- RENORM iteration:
  - low<256: PutBit(0).
  - low≥512: low-=512, PutBit(1).
  - Otherwise: low-=256, outstanding++.
  - Then range<<=1, low<<=1.
  - Exit to IDLE when range≥256.
- PutBit(b):
  - If firstBitFlag: clear it, emit nothing.
  - Else emit b this cycle.
  - If outstanding>0: go to OUTST and emit !b exactly outstanding times, clearing the count, then resume the caller (RENORM, IDLE or FLUSH_W1).
- i_flush (i_bypass ignored):
  - range-=2; low+=range; range=2.
  - RENORM (7 iterations), then FLUSH_PUT, FLUSH_W1, FLUSH_W2, then IDLE.
  - o_flush_done asserts with the FLUSH_W2 bit.
  - A new i_start is required before the next slice.

## Timing
- Reset values: o_bin_ready=1, o_bit_valid=0, o_bit=0, o_flush_done=0, o_err=0.
- Throughput is 1 bin/cycle while no renormalisation or outstanding flush is needed (o_bin_ready stays 1).
- o_bin_ready is 0 from the cycle after an accept that enters RENORM/OUTST/FLUSH until the cycle the FSM re-enters IDLE.
- o_bit/o_bit_valid are registered: a bit decided at edge E is valid during the cycle after E. At most one bit per cycle.
- Back-to-back regular bins on the same context see the updated state (write at edge, read next cycle).

## Test plan
- Reset: rst 2 cycles → o_bin_ready=1, o_bit_valid=0, o_err=0; internal range=510, low=0.
- MPS, no renorm: ctx0={0,0}, encode bin 0 → rLps=240, range=270, no bits, ctx0={1,0}, o_bin_ready stays 1 the next cycle.
- LPS with renorm: ctx0={0,0}, encode bin 1:
  - Arithmetic update: range=240, low=270; ctx0={0,1}.
  - One RENORM iteration: low=28, range=480, outstanding=1, no bits.
  - o_bin_ready low for 1 cycle.
- Bypass sequence 1,1,0,0,1 after start:
  - 1st bin: first bit suppressed.
  - 2nd bin: emits 1.
  - 3rd, 4th bins: outstanding=2.
  - 5th bin: emits 1,0,0 on consecutive cycles.
  - Final low=462.
- Flush immediately after start:
  - Renorm leaves low=0, range=256, outstanding=7.
  - Emitted stream is 1,1,1,1,1,1,1,0,1 (9 bits).
  - o_flush_done high with the last bit.
- Reset mid-OUTST: assert rst during the outstanding emission of the bypass test → next cycle o_bit_valid=0, o_bin_ready=1; ctx RAM contents unchanged; a fresh MPS encode on ctx0 matches the MPS scenario.
